// File: rtl/g_nand.sv
// Bitwise NAND leaf cell: combinational result plus a registered copy,
// a one-cycle change pulse and a saturating change counter.
module g_nand #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  // Counter increments by one when enabled and sticks at all ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  logic chg_p0;

  // Stage p0: combinational NAND, independent of clk/rst
  assign y      = ~(a & b);
  assign chg_p0 = (y != y_q);

  // Stage p1: observation registers; reset wins over capture and increment
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '1;
      y_chg   <= 1'b0;
      chg_cnt <= '0;
    end else begin
      y_q     <= y;
      y_chg   <= chg_p0;
      chg_cnt <= sat_inc(chg_cnt, chg_p0);
    end
  end

endmodule

// File: tb/tb_g_nand.sv
// Scoreboard bench for g_nand: a 1-bit instance with a 2-bit counter and a
// 4-bit instance with the default counter, driven from a directed table.
module tb_g_nand;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst, rst4;
  logic [0:0] a, b, y, y_q;
  logic       y_chg;
  logic [1:0] chg_cnt;
  logic [3:0] a4, b4, y4, y_q4;
  logic       y_chg4;
  logic [7:0] chg_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  g_nand #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .y(y), .y_q(y_q), .y_chg(y_chg), .chg_cnt(chg_cnt)
  );

  g_nand #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4),
    .y(y4), .y_q(y_q4), .y_chg(y_chg4), .chg_cnt(chg_cnt4)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       r, a, b, ey, eq, ec;
    logic [1:0] en;
    logic       r4;
    logic [3:0] a4, b4, ey4, eq4;
    logic       ec4;
    logic [7:0] en4;
  } row_t;

  typedef struct {
    int         cyc;
    logic       eq, ec;
    logic [1:0] en;
    logic [3:0] eq4;
    logic       ec4;
    logic [7:0] en4;
  } exp_t;

  exp_t exp_q[$];
  row_t rows[15];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: compares the registered outputs against queued expectations
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk($sformatf("y_q[%0d]", e.cyc),      {7'd0, y_q},      {7'd0, e.eq});
        chk($sformatf("y_chg[%0d]", e.cyc),    {7'd0, y_chg},    {7'd0, e.ec});
        chk($sformatf("chg_cnt[%0d]", e.cyc),  {6'd0, chg_cnt},  {6'd0, e.en});
        chk($sformatf("y_q4[%0d]", e.cyc),     {4'd0, y_q4},     {4'd0, e.eq4});
        chk($sformatf("y_chg4[%0d]", e.cyc),   {7'd0, y_chg4},   {7'd0, e.ec4});
        chk($sformatf("chg_cnt4[%0d]", e.cyc), chg_cnt4,         e.en4);
      end
    end
  end

  initial begin
    exp_t e;
    //          r    a    b    ey   eq   ec   en     r4   a4     b4     ey4    eq4    ec4  en4
    rows[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0, 1'b1,4'hC,4'hA,4'h7,4'hF,1'b0,8'd0};
    rows[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0, 1'b1,4'hC,4'hA,4'h7,4'hF,1'b0,8'd0};
    rows[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd1, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b1,8'd1};
    rows[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd1, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd1, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'd2, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd3, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'd3, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd3, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[10] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'd3, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[11] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,2'd1, 1'b0,4'hC,4'hA,4'h7,4'h7,1'b0,8'd1};
    rows[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd1, 1'b0,4'hF,4'hF,4'h0,4'h0,1'b1,8'd2};
    rows[14] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'd2, 1'b0,4'hF,4'hF,4'h0,4'h0,1'b0,8'd2};

    // Unclocked truth table, clock held low and reset undriven
    a4 = 4'b1100; b4 = 4'b1010;
    a = 1'b0; b = 1'b0; #10; chk("tt_00", {7'd0, y}, 8'd1);
    a = 1'b0; b = 1'b1; #10; chk("tt_01", {7'd0, y}, 8'd1);
    a = 1'b1; b = 1'b0; #10; chk("tt_10", {7'd0, y}, 8'd1);
    a = 1'b1; b = 1'b1; #10; chk("tt_11", {7'd0, y}, 8'd0);
    chk("bitwise_y4", {4'd0, y4}, 8'h07);

    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      rst = rows[i].r;   a = rows[i].a;   b = rows[i].b;
      rst4 = rows[i].r4; a4 = rows[i].a4; b4 = rows[i].b4;
      e.cyc = cyc + 1;
      e.eq = rows[i].eq;   e.ec = rows[i].ec;   e.en = rows[i].en;
      e.eq4 = rows[i].eq4; e.ec4 = rows[i].ec4; e.en4 = rows[i].en4;
      exp_q.push_back(e);
      if (i == 0) clk_en = 1'b1;
      #1;
      chk($sformatf("y_row%0d", i),  {7'd0, y},  {7'd0, rows[i].ey});
      chk($sformatf("y4_row%0d", i), {4'd0, y4}, {4'd0, rows[i].ey4});
    end

    // Glitch between edges must not be counted
    @(negedge clk);
    a = 1'b1; #1; a = 1'b0; #1;
    e.cyc = cyc + 1;
    e.eq = 1'b1; e.ec = 1'b0; e.en = 2'd2;
    e.eq4 = 4'h0; e.ec4 = 1'b0; e.en4 = 8'd2;
    exp_q.push_back(e);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
